// File: rtl/ledger_uart_tx_pkg.sv
// Shared types and ASCII constants for the ledger UART transmit path.
// Included by the top-level controller and by the byte serializer.
package ledger_uart_tx_pkg;

    localparam logic [7:0] ASCII_CR       = 8'h0D;
    localparam logic [7:0] ASCII_LF       = 8'h0A;
    localparam logic [7:0] ASCII_0        = 8'h30;
    localparam logic [7:0] ASCII_A_OFFSET = 8'h37;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_NEXT,
        ST_DONE
    } top_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } byte_state_t;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (ASCII_0 + {4'd0, nib}) : (ASCII_A_OFFSET + {4'd0, nib});
    endfunction

endpackage

// File: rtl/ledger_uart_tx_byte.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit, each CLKS_PER_BIT cycles.
// tx_done fires early so the next tx_go can land exactly on the last stop-bit cycle.
//
//   state    | meaning
//   TX_IDLE  | line high, waiting for tx_go
//   TX_START | driving the start bit (0)
//   TX_DATA  | shifting out data bits, LSB first
//   TX_STOP  | driving the stop bit (1); a tx_go on its last cycle chains the next byte
module ledger_uart_tx_byte
    import ledger_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       tx_go,
    input  logic [7:0] tx_data,
    output logic       tx_line,
    output logic       tx_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    // Three cycles ahead of the end: covers the controller's SEND->NEXT->LOAD hops.
    localparam logic [BAUD_W-1:0] DONE_AT   = BAUD_W'(CLKS_PER_BIT - 3);

    byte_state_t       state_q, state_d;
    logic [BAUD_W-1:0] baud_q;
    logic [3:0]        bit_q;
    logic [7:0]        shift_q;
    logic              bit_end;

    assign bit_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        tx_line = 1'b1;
        tx_done = 1'b0;
        case (state_q)
            TX_IDLE: ;
            TX_START: begin
                tx_line = 1'b0;
                if (bit_end) state_d = TX_DATA;
            end
            TX_DATA: begin
                tx_line = shift_q[0];
                if (bit_end && bit_q == 4'd8) state_d = TX_STOP;
            end
            TX_STOP: begin
                tx_done = (baud_q == DONE_AT);
                if (bit_end) state_d = TX_IDLE;
            end
            default: state_d = TX_IDLE;
        endcase
        if (tx_go) state_d = TX_START;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            if (tx_go) begin
                baud_q  <= '0;
                bit_q   <= '0;
                shift_q <= tx_data;
            end else if (state_q != TX_IDLE) begin
                if (bit_end) begin
                    baud_q <= '0;
                    bit_q  <= (state_q == TX_STOP) ? 4'd0 : bit_q + 4'd1;
                    if (state_q == TX_DATA) shift_q <= {1'b0, shift_q[7:1]};
                end else begin
                    baud_q <= baud_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ledger_uart_tx.sv
// Sends one captured RAM record as uppercase ASCII hex (MSB nibble first) plus CR LF over 8N1 UART.
// Bytes are chained back to back with no idle gap on the line.
//
//   state   | meaning
//   ST_IDLE | line forced high, waiting for start
//   ST_LOAD | present byte char_idx to the serializer, pulse tx_go
//   ST_SEND | byte on the wire, waiting for tx_done
//   ST_NEXT | advance char_idx, or let the final stop bit drain
//   ST_DONE | one-cycle done pulse, busy already low
module ledger_uart_tx
    import ledger_uart_tx_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200,
    parameter int WORD_W = 48
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [WORD_W-1:0] word_in,
    output logic              uart_tx,
    output logic              busy,
    output logic              done
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int NCHARS       = WORD_W / 4;
    localparam int IDX_W        = $clog2(NCHARS + 2);
    localparam logic [IDX_W-1:0] CR_IDX   = IDX_W'(NCHARS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHARS + 1);

    top_state_t        state_q, state_d;
    logic [WORD_W-1:0] shadow_q;
    logic [IDX_W-1:0]  char_idx_q;
    logic              drain_q;
    logic [3:0]        nibble;
    logic [7:0]        tx_data;
    logic              tx_go;
    logic              tx_line;
    logic              tx_done;

    always_comb begin
        nibble = '0;
        for (int i = 0; i < NCHARS; i++) begin
            if (char_idx_q == IDX_W'(i)) nibble = shadow_q[WORD_W-1-4*i -: 4];
        end
    end

    assign tx_data = (char_idx_q == CR_IDX)   ? ASCII_CR :
                     (char_idx_q == LAST_IDX) ? ASCII_LF : hex_ascii(nibble);

    always_comb begin
        state_d = state_q;
        tx_go   = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_LOAD;
            ST_LOAD: begin
                tx_go   = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: if (tx_done) state_d = ST_NEXT;
            ST_NEXT: begin
                // tx_done is early; after LF hold here until its stop bit has fully left
                if (char_idx_q != LAST_IDX) state_d = ST_LOAD;
                else if (drain_q)           state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            shadow_q   <= '0;
            char_idx_q <= '0;
            drain_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && start) begin
                shadow_q   <= word_in;
                char_idx_q <= '0;
                drain_q    <= 1'b0;
            end else if (state_q == ST_NEXT) begin
                if (char_idx_q != LAST_IDX) char_idx_q <= char_idx_q + 1'b1;
                else                        drain_q    <= 1'b1;
            end
        end
    end

    assign busy    = (state_q == ST_LOAD) || (state_q == ST_SEND) || (state_q == ST_NEXT);
    assign uart_tx = (state_q == ST_IDLE || state_q == ST_DONE) ? 1'b1 : tx_line;

    ledger_uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clock  (clock),
        .resetn (resetn),
        .tx_go  (tx_go),
        .tx_data(tx_data),
        .tx_line(tx_line),
        .tx_done(tx_done)
    );

endmodule

// File: tb/tb_ledger_uart_tx.sv
// Self-checking bench for ledger_uart_tx at CLKS_PER_BIT=8, against an ASCII-hex/8N1 line model.
module tb_ledger_uart_tx;

    localparam int CPB   = 8;
    localparam int NCH   = 12;
    localparam int NB    = NCH + 2;
    localparam int FRAME = NB * 10 * CPB;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [47:0] word_in = '0;
    logic        uart_tx;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clock = ~clock;

    ledger_uart_tx #(
        .CLK_HZ(8),
        .BAUD  (1),
        .WORD_W(48)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .start  (start),
        .word_in(word_in),
        .uart_tx(uart_tx),
        .busy   (busy),
        .done   (done)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_char(input logic [47:0] w, input int i);
        int n;
        if (i == NCH)     return 8'h0D;
        if (i == NCH + 1) return 8'h0A;
        n = int'((w >> (4 * (NCH - 1 - i))) & 48'hF);
        if (n < 10) return 8'(48 + n);     // '0'..'9'
        return 8'(65 + n - 10);            // 'A'..'F'
    endfunction

    // Expected line level at cycle c of a frame (cycle 0 = first start-bit cycle).
    function automatic logic ref_line(input logic [47:0] w, input int c);
        int b, k;
        logic [7:0] ch;
        b  = c / (10 * CPB);
        k  = (c % (10 * CPB)) / CPB;
        ch = ref_char(w, b);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return ch[k-1];
    endfunction

    task automatic send_start(input logic [47:0] w, input string tag);
        @(negedge clock);
        word_in = w;
        start   = 1'b1;
        @(negedge clock);
        start   = 1'b0;
        check_val({tag, ".busy_rise"}, busy, 1'b1);
    endtask

    // Sample waveform one frame long from the first start bit; returns at the done cycle.
    task automatic run_frame(input logic [47:0] w, input string tag, input int junk_at,
                             input bit toggle, output int gap);
        logic [7:0] got_ch [NB];
        logic [9:0] first_wire;
        int wire_err, seg_err, run, dn, b, k;
        logic prev;
        send_start(w, tag);
        gap = 0;
        while (uart_tx !== 1'b0 && gap < 20) begin
            @(negedge clock);
            gap++;
        end
        check_val({tag, ".start_bit_seen"}, (gap < 20), 1'b1);
        if (gap >= 20) return;
        wire_err = 0; seg_err = 0; run = 0; dn = 0; prev = 1'b0;
        first_wire = '0;
        for (int i = 0; i < NB; i++) got_ch[i] = '0;
        for (int c = 0; c < FRAME; c++) begin
            if (uart_tx !== ref_line(w, c)) wire_err++;
            if (uart_tx === prev) run++;
            else begin
                if (run % CPB != 0) seg_err++;
                run  = 1;
                prev = uart_tx;
            end
            if (done) dn++;
            if (c % CPB == CPB / 2) begin
                b = c / (10 * CPB);
                k = (c % (10 * CPB)) / CPB;
                if (k >= 1 && k <= 8) got_ch[b][k-1] = uart_tx;
                if (b == 0) first_wire[k] = uart_tx;
            end
            if (c == junk_at) begin
                start   = 1'b1;
                word_in = {$urandom(), $urandom()};
            end
            if (c == junk_at + 1) start = 1'b0;
            if (toggle) word_in = {$urandom(), $urandom()};
            @(negedge clock);
        end
        if (run % CPB != 0) seg_err++;
        for (int i = 0; i < NB; i++)
            check_val($sformatf("%s.char%0d", tag, i), got_ch[i], ref_char(w, i));
        check_val({tag, ".wire_errs"}, wire_err, 0);
        check_val({tag, ".seg_width_errs"}, seg_err, 0);
        check_val({tag, ".first_byte_wire"}, first_wire, {1'b1, ref_char(w, 0), 1'b0});
        check_val({tag, ".early_done"}, dn, 0);
        check_val({tag, ".done_at_end"}, done, 1'b1);
        check_val({tag, ".busy_at_done"}, busy, 1'b0);
    endtask

    initial begin
        int gap, errs, dn;
        logic [47:0] w;

        repeat (3) @(negedge clock);
        check_val("reset.uart_tx", uart_tx, 1'b1);
        check_val("reset.busy", busy, 1'b0);
        check_val("reset.done", done, 1'b0);
        resetn = 1'b1;

        errs = 0;
        repeat (1000) begin
            @(negedge clock);
            if (uart_tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) errs++;
        end
        check_val("idle.errs", errs, 0);

        run_frame(48'h0123456789AB, "framing", -1, 1'b0, gap);
        run_frame(48'hFFFFFFFFFFFF, "all_f", -1, 1'b0, gap);

        w = {$urandom(), $urandom()};
        run_frame(w, "busy_ignore", 2 * 10 * CPB + 20, 1'b1, gap);
        dn = 0; errs = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) dn++;
            if (busy !== 1'b0 || uart_tx !== 1'b1) errs++;
        end
        check_val("busy_ignore.extra_done", dn, 0);
        check_val("busy_ignore.no_queued_frame", errs, 0);

        w = {$urandom(), $urandom()};
        run_frame(w, "b2b_first", -1, 1'b0, gap);
        run_frame(48'h0, "b2b_second", -1, 1'b0, gap);
        check_val("b2b.gap_under_one_bit", (gap < CPB), 1'b1);

        // Reset during the data bits of byte 5.
        w = {$urandom(), $urandom()};
        send_start(w, "rst_mid");
        gap = 0;
        while (uart_tx !== 1'b0 && gap < 20) begin
            @(negedge clock);
            gap++;
        end
        check_val("rst_mid.start_bit_seen", (gap < 20), 1'b1);
        repeat (4 * 10 * CPB + 4 * CPB) @(negedge clock);
        check_val("rst_mid.busy_before", busy, 1'b1);
        resetn = 1'b0;
        #1;
        check_val("rst_mid.uart_tx", uart_tx, 1'b1);
        check_val("rst_mid.busy", busy, 1'b0);
        check_val("rst_mid.done", done, 1'b0);
        repeat (5) @(negedge clock);
        resetn = 1'b1;
        dn = 0; errs = 0;
        repeat (200) begin
            @(negedge clock);
            if (done) dn++;
            if (busy !== 1'b0 || uart_tx !== 1'b1) errs++;
        end
        check_val("rst_mid.no_done", dn, 0);
        check_val("rst_mid.abandoned", errs, 0);

        w = {$urandom(), $urandom()};
        run_frame(w, "after_reset", -1, 1'b0, gap);
        for (int r = 0; r < 3; r++) begin
            w = {$urandom(), $urandom()};
            run_frame(w, $sformatf("rand%0d", r), -1, 1'b0, gap);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
